// File: rtl/extend_pkg.sv
// rtl/extend_pkg.sv - shared constants for the immediate extender
// Contents:
//   EXT_ZERO / EXT_SIGN : values of the ExtSel mode select
//   IMM_W / WORD_W      : default immediate and datapath widths
package extend_pkg;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

endpackage

// File: rtl/extend_core.sv
// rtl/extend_core.sv - combinational zero/sign (and optional LUI) extension
// Optional feature macro: EXTEND_LUI_EN (adds ext_lui, upper-immediate form)
// Ports:
//   ext_addr [IN_W]  : immediate field to widen
//   ext_sel          : EXT_ZERO = zero-extend, EXT_SIGN = sign-extend
//   ext_lui          : (EXTEND_LUI_EN only) place immediate in the upper bits
//   ext_out  [OUT_W] : widened value
module extend_core
  import extend_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic [IN_W-1:0]  ext_addr,
  input  logic             ext_sel,
`ifdef EXTEND_LUI_EN
  input  logic             ext_lui,
`endif
  output logic [OUT_W-1:0] ext_out
);

  // Number of fill bits added above (or, for LUI, below) the immediate.
  localparam int PAD_W = OUT_W - IN_W;

  always_comb begin
    ext_out = {{PAD_W{1'b0}}, ext_addr};
    if (ext_sel == EXT_SIGN) begin
      ext_out = {{PAD_W{ext_addr[IN_W-1]}}, ext_addr};
    end
`ifdef EXTEND_LUI_EN
    // LUI overrides either extension mode.
    if (ext_lui) begin
      ext_out = {ext_addr, {PAD_W{1'b0}}};
    end
`endif
  end

endmodule

// File: rtl/extend_unit.sv
// rtl/extend_unit.sv - registered immediate extender with one-cycle valid strobe
// Optional feature macro: EXTEND_LUI_EN (adds ExtLui input)
// Ports:
//   CLK              : clock, rising edge
//   Reset            : synchronous active-high reset, wins over ExtEn
//   ExtEn            : capture ExtAddr/ExtSel this cycle
//   ExtAddr [IN_W]   : immediate field
//   ExtSel           : 0 = zero-extend, 1 = sign-extend
//   ExtLui           : (EXTEND_LUI_EN only) upper-immediate form, beats ExtSel
//   ExtOut  [OUT_W]  : registered result, holds while ExtEn is low
//   ExtValid         : high one cycle after each accepted ExtEn
module extend_unit
  import extend_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W   // must exceed IN_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             ExtEn,
  input  logic [IN_W-1:0]  ExtAddr,
  input  logic             ExtSel,
`ifdef EXTEND_LUI_EN
  input  logic             ExtLui,
`endif
  output logic [OUT_W-1:0] ExtOut,
  output logic             ExtValid
);

  logic [OUT_W-1:0] ext_val;
  logic [OUT_W-1:0] ext_out_d, ext_out_q;
  logic             ext_valid_d, ext_valid_q;

  extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .ext_addr (ExtAddr),
    .ext_sel  (ExtSel),
`ifdef EXTEND_LUI_EN
    .ext_lui  (ExtLui),
`endif
    .ext_out  (ext_val)
  );

  // Result register holds when no new immediate is offered; valid is a pure
  // one-cycle echo of ExtEn so back-to-back inputs keep it high.
  always_comb begin
    ext_out_d   = ext_out_q;
    ext_valid_d = ExtEn;
    if (ExtEn) begin
      ext_out_d = ext_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ext_out_q   <= '0;
      ext_valid_q <= 1'b0;
    end else begin
      ext_out_q   <= ext_out_d;
      ext_valid_q <= ext_valid_d;
    end
  end

  assign ExtOut   = ext_out_q;
  assign ExtValid = ext_valid_q;

endmodule

// File: tb/tb_extend_unit.sv
// tb/tb_extend_unit.sv - randomized self-checking bench for extend_unit
module tb_extend_unit;

  logic        clk;
  logic        reset;
  logic        ext_en;
  logic [15:0] ext_addr;
  logic        ext_sel;
  logic        ext_lui;
  logic [31:0] ext_out;
  logic        ext_valid;

  int n_vec;
  int n_err;

  logic [31:0] exp_out;
  logic        exp_valid;

  extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .CLK      (clk),
    .Reset    (reset),
    .ExtEn    (ext_en),
    .ExtAddr  (ext_addr),
    .ExtSel   (ext_sel),
`ifdef EXTEND_LUI_EN
    .ExtLui   (ext_lui),
`endif
    .ExtOut   (ext_out),
    .ExtValid (ext_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: widen a 16-bit value to 32 bits by plain arithmetic.
  function automatic logic [31:0] ext_model(input logic [15:0] a, input logic sel, input logic lui);
    logic [31:0] v;
    v = 32'(a);
    if (lui) return v * 32'd65536;
    if (sel && a >= 16'h8000) return v + 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic lui_active();
`ifdef EXTEND_LUI_EN
    return ext_lui;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural register model, updated on each rising edge.
  initial begin
    exp_out   = 32'h0;
    exp_valid = 1'b0;
  end
  always @(posedge clk) begin
    if (reset) begin
      exp_out   = 32'h0;
      exp_valid = 1'b0;
    end else if (ext_en) begin
      exp_out   = ext_model(ext_addr, ext_sel, lui_active());
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
  end

  // Compare process: every cycle, shortly after the edge.
  always @(posedge clk) begin
    #1;
    n_vec++;
    if (ext_out !== exp_out || ext_valid !== exp_valid) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t: got out=%h valid=%b, expected out=%h valid=%b",
               $time, ext_out, ext_valid, exp_out, exp_valid);
    end
  end

  task automatic check_lit(input string name, input logic [31:0] exp_o, input logic exp_v);
    n_vec++;
    if (ext_out !== exp_o || ext_valid !== exp_v) begin
      n_err++;
      $display("FAIL %s: got out=%h valid=%b, expected out=%h valid=%b",
               name, ext_out, ext_valid, exp_o, exp_v);
    end
  endtask

  // Drive inputs on the falling edge, then land just after the next rising edge.
  task automatic step(input logic rst, input logic en, input logic sel,
                      input logic [15:0] addr, input logic lui);
    @(negedge clk);
    reset    = rst;
    ext_en   = en;
    ext_sel  = sel;
    ext_addr = addr;
    ext_lui  = lui;
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    ext_en   = 1'b1;
    ext_sel  = 1'b0;
    ext_addr = 16'hFFE0;
    ext_lui  = 1'b0;

    // Reset wins over ExtEn for two cycles.
    @(posedge clk); #2;
    step(1, 1, 0, 16'hFFE0, 0);
    check_lit("reset", 32'h0000_0000, 1'b0);

    step(0, 1, 0, 16'hFFE0, 0); check_lit("zero_ffe0",  32'h0000_FFE0, 1'b1);
    step(0, 1, 1, 16'hFFE0, 0); check_lit("sign_ffe0",  32'hFFFF_FFE0, 1'b1);
    step(0, 1, 1, 16'h8000, 0); check_lit("sign_8000",  32'hFFFF_8000, 1'b1);
    step(0, 1, 0, 16'h8000, 0); check_lit("zero_8000",  32'h0000_8000, 1'b1);
    step(0, 1, 1, 16'h7FFF, 0); check_lit("sign_7fff",  32'h0000_7FFF, 1'b1);
    step(0, 1, 0, 16'h7FFF, 0); check_lit("zero_7fff",  32'h0000_7FFF, 1'b1);
    step(0, 1, 1, 16'h0000, 0); check_lit("sign_0",     32'h0000_0000, 1'b1);
    step(0, 1, 0, 16'h0000, 0); check_lit("zero_0",     32'h0000_0000, 1'b1);

    // Single strobe then hold while the don't-care inputs wander.
    step(0, 1, 0, 16'h1234, 0); check_lit("pulse_1234", 32'h0000_1234, 1'b1);
    step(0, 0, 1, 16'hFFFF, 0); check_lit("hold_a",     32'h0000_1234, 1'b0);
    step(0, 0, 0, 16'h5A5A, 0); check_lit("hold_b",     32'h0000_1234, 1'b0);

    // Back-to-back accepts.
    step(0, 1, 1, 16'h0001, 0); check_lit("b2b_0001",   32'h0000_0001, 1'b1);
    step(0, 1, 1, 16'hFFFF, 0); check_lit("b2b_ffff",   32'hFFFF_FFFF, 1'b1);

    // Mid-run reset drops a concurrent input.
    step(1, 1, 1, 16'hFFFF, 0); check_lit("mid_reset",  32'h0000_0000, 1'b0);

`ifdef EXTEND_LUI_EN
    step(0, 1, 1, 16'hABCD, 1); check_lit("lui_abcd",   32'hABCD_0000, 1'b1);
    step(0, 1, 0, 16'h8001, 1); check_lit("lui_8001",   32'h8001_0000, 1'b1);
`endif

    // Randomized traffic with boundary-biased immediates.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 7))
        0:       a = 16'h0000;
        1:       a = 16'h8000;
        2:       a = 16'h7FFF;
        3:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), a, ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/extend_unit.md
Name: extend_unit

Overview:
- Immediate extender for the single-cycle MIPS datapath; feeds the ALU B-operand mux and the branch-offset adder.
- Widens a 16-bit instruction immediate to 32 bits by zero-extension or sign-extension, selected by ExtSel.
- Result is registered: one-cycle latency with a valid strobe, so the block can also sit on a pipelined datapath.

Parameters:
- IN_W, 16, width of the immediate input ExtAddr.
- OUT_W, 32, width of the extended output ExtOut; must be > IN_W.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- ExtEn  input  1  input-valid strobe; when high, ExtAddr/ExtSel are captured this cycle.
- ExtAddr  input  IN_W  immediate field (instr[15:0]).
- ExtSel  input  1  mode select: 0 = zero-extend, 1 = sign-extend.
- ExtOut  output  OUT_W  registered extended value.
- ExtValid  output  1  high for exactly one cycle after each accepted ExtEn.

Behaviour:
- Only register state: ExtOut and ExtValid, both updated on the rising edge of CLK.
- Reset high at a clock edge:
  - ExtOut <= 0 and ExtValid <= 0.
  - Reset has priority over ExtEn in the same cycle; the input is dropped.
- Reset low and ExtEn high:
  - ExtOut <= ext(ExtAddr, ExtSel) and ExtValid <= 1.
  - Latency is exactly 1 cycle.
- Reset low and ExtEn low: ExtOut holds its previous value; ExtValid <= 0.
- ext() arithmetic:
  - ExtSel = 0: upper OUT_W-IN_W bits are 0, lower IN_W bits are ExtAddr.
  - ExtSel = 1: upper OUT_W-IN_W bits are copies of ExtAddr[IN_W-1], lower IN_W bits are ExtAddr.
- No handshake back-pressure: the block accepts a new input every cycle. Back-to-back ExtEn gives back-to-back results, with ExtValid held high continuously.
- Boundary values:
  - ExtAddr = 0: output 0 in both modes.
  - ExtAddr = 0x8000: 0x00008000 when zero-extended, 0xFFFF8000 when sign-extended.
- ExtSel and ExtAddr are don't-care while ExtEn is low.
- No X propagation from the register after reset.

Optional Feature:
- Macro: EXTEND_LUI_EN.
- When defined:
  - Adds input ExtLui (1 bit).
  - When ExtEn and ExtLui are high, ExtOut <= {ExtAddr, (OUT_W-IN_W) zeros} (LUI upper-immediate form).
  - ExtLui has priority over ExtSel.
  - Reset behaviour is unchanged.
- When not defined: the ExtLui port does not exist, and only the zero/sign modes are supported.

Decomposition:
- Package extend_pkg:
  - constants EXT_ZERO = 1'b0 and EXT_SIGN = 1'b1;
  - default widths IMM_W = 16 and WORD_W = 32.
- One sub-module is natural: extend_core.
  - Purely combinational: computes ext() (and the LUI form under EXTEND_LUI_EN).
  - extend_unit wraps it with the output register and the valid flop.

Test Plan:
- Reset: hold Reset high for 2 cycles with ExtEn=1, ExtAddr=0xFFE0 -> ExtOut=0x00000000, ExtValid=0.
- Zero-extend: ExtEn=1, ExtSel=0, ExtAddr=0xFFE0 -> next cycle ExtOut=0x0000FFE0, ExtValid=1.
- Sign-extend negative: ExtEn=1, ExtSel=1, ExtAddr=0xFFE0 -> next cycle ExtOut=0xFFFFFFE0. ExtAddr=0x8000 -> 0xFFFF8000.
- Sign-extend positive: ExtSel=1, ExtAddr=0x7FFF -> 0x00007FFF. Same input with ExtSel=0 -> 0x00007FFF.
- Hold/strobe: apply one ExtEn pulse with 0x1234, then ExtEn=0 with ExtAddr changing -> ExtOut stays 0x00001234 and ExtValid is high for 1 cycle only. Back-to-back ExtEn (0x0001, 0xFFFF sign) -> outputs 0x00000001 then 0xFFFFFFFF on consecutive cycles.
- EXTEND_LUI_EN build: ExtLui=1, ExtSel=1, ExtAddr=0xABCD -> ExtOut=0xABCD0000.
